// File: rtl/ifu_axi_fetch_bridge.sv
// Fetch-port to AXI4-Lite read bridge: one AR/R transaction per fetch request and a
// one-cycle response pulse. Misaligned requests are answered locally with an error.
module ifu_axi_fetch_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [2:0]  ARPROT_VAL     = 3'b100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_addr,
   input  logic        i_addr_valid,
   output logic        i_rdata_valid,
   output logic [31:0] i_rdata,
   output logic        i_rerr,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [2:0]  m_arprot,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic        fetch_timeout
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] araddr_q, araddr_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;
   logic [31:0] wd_cnt_q;
   logic        timeout_q;
   logic        busy;

   // Only the upper response bit distinguishes an error (SLVERR/DECERR).
   logic unused_rresp_lsb;
   assign unused_rresp_lsb = m_rresp[0];

   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      rdata_d  = rdata_q;
      rerr_d   = rerr_q;
      case (state_q)
         StIdle: begin
            if (i_addr_valid) begin
               if (i_addr[1:0] == 2'b00) begin
                  araddr_d = i_addr;
                  state_d  = StAddr;
               end else begin
                  rdata_d = '0;
                  rerr_d  = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StAddr: begin
            if (m_arready) state_d = StData;
         end
         StData: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               rerr_d  = m_rresp[1];
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         araddr_q <= '0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

   assign busy = (state_q == StAddr) || (state_q == StData);

   // Watchdog only observes; a stalled transaction is left to complete.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (!busy) begin
            wd_cnt_q <= '0;
         end else if (wd_cnt_q != TIMEOUT_CYCLES) begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
         end
         if ((TIMEOUT_CYCLES != 0) && (wd_cnt_q == TIMEOUT_CYCLES)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign i_rdata_valid = (state_q == StDone);
   assign i_rdata       = rdata_q;
   assign i_rerr        = rerr_q;
   assign m_araddr      = araddr_q;
   assign m_arvalid     = (state_q == StAddr);
   assign m_rready      = (state_q == StData);
   assign m_arprot      = ARPROT_VAL;
   assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_ifu_axi_fetch_bridge.sv
// Directed plus randomized bench for ifu_axi_fetch_bridge; the bench itself plays the
// fetch stage and a configurable-latency AXI slave, and predicts every response.
module tb_ifu_axi_fetch_bridge;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr;
   logic        i_addr_valid;
   logic        i_rdata_valid;
   logic [31:0] i_rdata;
   logic        i_rerr;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready;
   logic [2:0]  m_arprot;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;
   logic        fetch_timeout;

   int checks = 0;
   int errors = 0;
   int to_c;

   ifu_axi_fetch_bridge #(
      .TIMEOUT_CYCLES(TO),
      .ARPROT_VAL    (3'b100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_addr_valid (i_addr_valid),
      .i_rdata_valid(i_rdata_valid),
      .i_rdata      (i_rdata),
      .i_rerr       (i_rerr),
      .m_araddr     (m_araddr),
      .m_arvalid    (m_arvalid),
      .m_arready    (m_arready),
      .m_arprot     (m_arprot),
      .m_rdata      (m_rdata),
      .m_rresp      (m_rresp),
      .m_rvalid     (m_rvalid),
      .m_rready     (m_rready),
      .fetch_timeout(fetch_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; i_addr_valid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One fetch: the slave answers AR after ar_dly waiting cycles and R after r_dly.
   task automatic fetch(input logic [31:0] addr, input int ar_dly, input int r_dly,
                        input logic [31:0] data, input logic [1:0] resp,
                        input bit toggle, input bit junk_r);
      int c, arv, hs, rw;
      bit done, aligned;
      logic [31:0] exp_data;
      logic exp_err;
      aligned  = (addr % 4) == 0;
      exp_data = aligned ? data : 32'h0;
      exp_err  = aligned ? resp[1] : 1'b1;
      @(negedge clk);
      i_addr = addr; i_addr_valid = 1'b1; m_arready = 1'b0; m_rvalid = 1'b0;
      c = 0; arv = 0; hs = 0; rw = 0; done = 1'b0; to_c = -1;
      while (!done && c < 200) begin
         @(negedge clk);
         c++;
         if (fetch_timeout && to_c < 0) to_c = c;
         if (toggle) i_addr = $urandom;
         m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = $urandom; m_rresp = 2'($urandom);
         if (m_arvalid) begin
            chk("araddr_stable", m_araddr, addr);
            chk("arvalid_excl_rready", {31'b0, m_rready}, 32'd0);
            if (arv == ar_dly) begin
               m_arready = 1'b1;
               hs++;
            end else if (junk_r) begin
               m_rvalid = 1'b1;
            end
            arv++;
         end
         if (m_rready) begin
            chk("rready_after_ar", hs, 1);
            if (rw == r_dly) begin
               m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
            end
            rw++;
         end
         if (i_rdata_valid) begin
            done = 1'b1;
            i_addr_valid = 1'b0;
            chk("rdata", i_rdata, exp_data);
            chk("rerr", {31'b0, i_rerr}, {31'b0, exp_err});
            chk("latency", c, aligned ? 3 + ar_dly + r_dly : 1);
            chk("arvalid_cycles", arv, aligned ? ar_dly + 1 : 0);
            chk("ar_handshakes", hs, aligned ? 1 : 0);
         end
      end
      if (!done) begin
         chk("fetch_completes", 0, 1);
         do_reset();
      end else begin
         @(negedge clk);
         chk("valid_one_cycle", {31'b0, i_rdata_valid}, 32'd0);
         chk("rdata_hold", i_rdata, exp_data);
         chk("rerr_hold", {31'b0, i_rerr}, {31'b0, exp_err});
      end
   endtask

   initial begin
      rst = 1'b1; i_addr = '0; i_addr_valid = 1'b0;
      m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rdata_valid", {31'b0, i_rdata_valid}, 32'd0);
      chk("rst_rdata", i_rdata, 32'd0);
      chk("rst_rerr", {31'b0, i_rerr}, 32'd0);
      chk("rst_arvalid", {31'b0, m_arvalid}, 32'd0);
      chk("rst_araddr", m_araddr, 32'd0);
      chk("rst_rready", {31'b0, m_rready}, 32'd0);
      chk("rst_timeout", {31'b0, fetch_timeout}, 32'd0);
      chk("arprot", {29'b0, m_arprot}, 32'd4);
      rst = 1'b0;

      fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 2'b00, 1'b0, 1'b0);
      fetch(32'h8000_0002, 0, 0, 32'h1234_5678, 2'b00, 1'b0, 1'b0);
      fetch(32'h8000_0008, 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
      fetch(32'h8000_000C, 0, 0, 32'h0000_0013, 2'b00, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         fetch(a, $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 2'($urandom),
               1'($urandom), 1'($urandom));
      end
      chk("no_timeout_short_fetches", {31'b0, fetch_timeout}, 32'd0);

      fetch(32'h8000_0004, 3, 5, 32'hCAFE_F00D, 2'b01, 1'b1, 1'b1);

      do_reset();
      fetch(32'h8000_0010, 15, 0, 32'h0000_0093, 2'b00, 1'b0, 1'b0);
      chk("timeout_rise_window", {31'b0, (to_c >= int'(TO) + 1) && (to_c <= int'(TO) + 2)}, 32'd1);
      chk("timeout_sticky", {31'b0, fetch_timeout}, 32'd1);
      fetch(32'h8000_0014, 0, 0, 32'h0000_0113, 2'b00, 1'b0, 1'b0);
      chk("timeout_sticky_after_fetch", {31'b0, fetch_timeout}, 32'd1);

      // Reset while the bridge waits for R data.
      @(negedge clk);
      i_addr = 32'h8000_0020; i_addr_valid = 1'b1; m_arready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("in_data_phase", {31'b0, m_rready}, 32'd1);
      rst = 1'b1; i_addr_valid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_rdata_valid", {31'b0, i_rdata_valid}, 32'd0);
      chk("midrst_rdata", i_rdata, 32'd0);
      chk("midrst_rerr", {31'b0, i_rerr}, 32'd0);
      chk("midrst_arvalid", {31'b0, m_arvalid}, 32'd0);
      chk("midrst_araddr", m_araddr, 32'd0);
      chk("midrst_rready", {31'b0, m_rready}, 32'd0);
      chk("midrst_timeout", {31'b0, fetch_timeout}, 32'd0);
      fetch(32'h8000_0024, 1, 1, 32'h0040_0513, 2'b00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu_axi_fetch_bridge.md
Name: ifu_axi_fetch_bridge

Overview:
- Bridges the fetch unit's level-held request port (i_addr/i_addr_valid -> i_rdata_valid/i_rdata) to an AXI4-Lite read-only master interface toward instruction memory or the crossbar.
- Sits directly upstream of the fetch stage, between it and the memory system.
- Issues exactly one AR/R transaction per fetch request and returns a one-cycle data-valid pulse.
- Flags misaligned fetches, error responses, and stalled transactions.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles spent in S_ADDR+S_DATA before fetch_timeout is set; 0 disables the watchdog.
- ARPROT_VAL, 3'b100, constant driven on m_arprot (instruction, secure, unprivileged).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_addr  in  32  fetch address; valid while i_addr_valid=1
- i_addr_valid  in  1  fetch request; held high by the fetch stage until i_rdata_valid
- i_rdata_valid  out  1  one-cycle pulse: i_rdata/i_rerr valid
- i_rdata  out  32  fetched instruction word
- i_rerr  out  1  fetch error; qualified by i_rdata_valid
- m_araddr  out  32  AXI read address
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_arprot  out  3  AXI protection; constant ARPROT_VAL
- m_rdata  in  32  AXI read data
- m_rresp  in  2  AXI read response
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready
- fetch_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state S_IDLE; i_rdata_valid=0; i_rdata=0; i_rerr=0; m_arvalid=0; m_araddr=0; m_rready=0; fetch_timeout=0; watchdog counter=0.
- All outputs are registered or decoded from state only (Moore). There is no combinational path from any input to any output.
- States: S_IDLE, S_ADDR, S_DATA, S_DONE.
- S_IDLE, i_addr_valid=1, i_addr[1:0]==0:
  - latch i_addr into m_araddr;
  - go to S_ADDR.
- S_IDLE, i_addr_valid=1, i_addr[1:0]!=0:
  - no bus transaction;
  - i_rdata<=0, i_rerr<=1;
  - go to S_DONE.
- S_IDLE, i_addr_valid=0: stay in S_IDLE.
- S_ADDR:
  - m_arvalid=1; m_araddr held stable.
  - On m_arready=1, go to S_DATA.
  - i_addr changes while in S_ADDR/S_DATA are ignored (the address is latched).
- S_DATA:
  - m_rready=1.
  - On m_rvalid=1: i_rdata<=m_rdata; i_rerr<=m_rresp[1] (SLVERR/DECERR=1, OKAY/EXOKAY=0); go to S_DONE.
- S_DONE:
  - i_rdata_valid=1 for exactly this cycle.
  - Unconditionally go to S_IDLE.
  - i_rdata/i_rerr hold their values until the next response is captured.
- Minimum latency with a zero-wait slave: request sampled at cycle N; m_arvalid at N+1; R accepted at N+2; i_rdata_valid at N+3.
- No re-issue: the fetch stage drops i_addr_valid the cycle after i_rdata_valid. A request seen again in S_IDLE is a new fetch.
- At most one outstanding transaction; m_arvalid and m_rready are never both 1.
- m_rvalid outside S_DATA is ignored (protocol violation; no state change).
- Watchdog:
  - Counter increments each cycle in S_ADDR or S_DATA and clears on entering S_IDLE.
  - It saturates at TIMEOUT_CYCLES.
  - When count==TIMEOUT_CYCLES (and the parameter is nonzero), fetch_timeout<=1. It stays set until rst.
  - The transaction is not aborted.
- Reset mid-transaction: return to S_IDLE immediately and drop m_arvalid/m_rready. The memory system shares rst, so the abandoned transaction needs no cleanup.

Test Plan:
- Zero-wait slave, request 0x80000000, slave data 0x00000413 OKAY -> araddr=0x80000000; i_rdata_valid high exactly at N+3 for 1 cycle; i_rdata=0x00000413; i_rerr=0; exactly one AR handshake.
- arready delayed 3 cycles, rvalid delayed 5 cycles on 0x80000004 -> m_araddr stable while m_arvalid=1; m_rready only after the AR handshake; i_rdata_valid one cycle after rvalid; i_addr toggled mid-transaction has no effect.
- Misaligned address 0x80000002 -> no m_arvalid ever; i_rdata_valid at N+1 with i_rerr=1, i_rdata=0.
- m_rresp=2'b10 (SLVERR) with rdata 0xDEADBEEF -> i_rdata=0xDEADBEEF, i_rerr=1; next OKAY fetch returns i_rerr=0.
- TIMEOUT_CYCLES=8, arready tied 0 -> fetch_timeout rises after 8 cycles in S_ADDR and stays high. Releasing arready completes the fetch normally; the flag stays high.
- rst asserted while in S_DATA -> next cycle all outputs at reset values, state S_IDLE. A new request after reset completes normally and generates a single AR.
